queen_check: RTL and testbench
==============================

# queen_check

Streaming verifier for N-queens placements: the consuming end of the solver's board stream. Accepts one column index per row over a valid/ready handshake, keeps column and diagonal occupancy masks, and returns a per-board verdict through a second handshake. It also keeps a running count of accepted legal boards, so a bench or host can compare it against the solver's solution count.

## Interface
- N, 11, board size (rows = columns), 2..31
- LN, 5, width of a row/column index, 2^LN > N
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  placement beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_col  input  LN  column of the queen in the current row (rows implicit, 0 first)
- in_last  input  1  marks final beat of a board
- res_valid  output  1  verdict available
- res_ready  input  1  verdict consumed when res_valid && res_ready
- res_code  output  2  00 legal, 01 attack, 10 column out of range, 11 wrong row count
- good_cnt  output  32  number of legal boards consumed

## Operation
- Two states, registered: COLLECT and REPORT. Reset enters COLLECT.
- In COLLECT: in_ready=1, res_valid=0. In REPORT: in_ready=0, res_valid=1.
- State held internally:
  - row counter r (LN bits, saturates at N)
  - masks mh[N], ms[2N-1], md[2N-1]
  - sticky error flags err_att, err_rng, err_len
- Each accepted beat with column c, while r<N:
  - c>=N: set err_rng; masks unchanged (no out-of-range indexing).
  - else if mh[c] | ms[r+c] | md[N-1-r+c]: set err_att; masks still set.
  - else: set mh[c], ms[r+c], md[N-1-r+c].
  - r<=r+1.
- Beat accepted with r==N (over-long board): set err_len, no mask or range checks; r stays N.
- Beat with in_last:
  - err_len is also set if the beat's row index != N-1.
  - Move to REPORT.
  - Verdict priority: len > rng > att > legal.
- res_code is registered and stable for the whole REPORT interval.
- Verdict handshake in REPORT:
  - Clear masks, r, and error flags; return to COLLECT.
  - If res_code==00, good_cnt<=good_cnt+1 (wraps modulo 2^32).
- A board is never dropped. Rows beyond N are absorbed until in_last.
- Index arithmetic is done at LN+1 bits to avoid truncation of r+c and N-1-r+c.

## Timing
- Reset (async assert, sync-released deassert assumed by system) values:
  - state=COLLECT, in_ready=1, res_valid=0, res_code=00
  - good_cnt=0, masks/r/flags=0
- in_ready and res_valid decode from registered state only; no combinational path from in_valid or res_ready.
- Latency: res_valid rises the cycle after the in_last beat is accepted.
- Throughput: with res_ready tied high, one board per N+1 cycles; in_ready rises the cycle after the verdict handshake.
- good_cnt updates on the clock edge of the verdict handshake and is visible the next cycle.
- in_valid while in REPORT: ignored, not accepted; the source must hold its beat.
- rst_n low at any point, including mid-board or during REPORT, discards the partial board and verdict immediately. good_cnt returns to 0.

## Test plan
- N=4, beats 1,3,0,2 (last on 2), res_ready=1: res_code=00 one cycle after last, good_cnt=1, in_ready back to 1 next cycle.
- N=4, beats 0,1,3,2: diagonal hit at row 1 gives res_code=01, good_cnt unchanged.
- N=4, beats 1,3,4,2: res_code=10. Then a legal board 2,0,3,1 gives 00, showing masks were cleared.
- N=4 short board (3 beats, last on third) and long board (6 beats): both give res_code=11. The long board keeps in_ready=1 until last.
- Backpressure: legal board, res_ready low for 5 cycles. res_valid and res_code hold, in_ready=0, in_valid beats are not accepted. Count increments only at the handshake.
- rst_n pulsed low after 2 beats: in_ready=1, res_valid=0, good_cnt=0. Next full legal board gives 00 with good_cnt=1.

Source files
------------

// File: rtl/queen_check.sv
// Streaming N-queens placement verifier: one column per row in, one verdict per board out.
// Keeps column/diagonal occupancy masks and a running count of legal boards.
module queen_check #(
    parameter int N  = 11,
    parameter int LN = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LN-1:0] in_col,
    input  logic          in_last,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [1:0]    res_code,
    output logic [31:0]   good_cnt
);

    localparam int NM = 2 * N - 1;

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [LN-1:0]   r_q, r_d;
    logic [N-1:0]    mh_q, mh_d;
    logic [NM-1:0]   ms_q, ms_d;
    logic [NM-1:0]   md_q, md_d;
    logic            err_att_q, err_att_d;
    logic            err_rng_q, err_rng_d;
    logic            err_len_q, err_len_d;
    logic [1:0]      code_q, code_d;
    logic [31:0]     cnt_q, cnt_d;

    // One extra bit so r+c and N-1-r+c never truncate.
    logic [LN:0]     col_ext, row_ext, s_idx, d_idx;
    logic [N-1:0]    col_oh;
    logic [NM-1:0]   s_oh, d_oh;
    logic            full, in_rng, hit, beat_fire, res_fire;

    assign col_ext = {1'b0, in_col};
    assign row_ext = {1'b0, r_q};
    assign s_idx   = row_ext + col_ext;
    assign d_idx   = (LN+1)'(N - 1) - row_ext + col_ext;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_col
            assign col_oh[gi] = (col_ext == (LN+1)'(gi));
        end
        for (genvar gi = 0; gi < NM; gi++) begin : g_diag
            assign s_oh[gi] = (s_idx == (LN+1)'(gi));
            assign d_oh[gi] = (d_idx == (LN+1)'(gi));
        end
    endgenerate

    assign full      = (r_q == LN'(N));
    assign in_rng    = (col_ext < (LN+1)'(N));
    assign hit       = (|(mh_q & col_oh)) || (|(ms_q & s_oh)) || (|(md_q & d_oh));
    assign in_ready  = (state_q == COLLECT);
    assign res_valid = (state_q == REPORT);
    assign beat_fire = in_ready && in_valid;
    assign res_fire  = res_valid && res_ready;
    assign res_code  = code_q;
    assign good_cnt  = cnt_q;

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        mh_d      = mh_q;
        ms_d      = ms_q;
        md_d      = md_q;
        err_att_d = err_att_q;
        err_rng_d = err_rng_q;
        err_len_d = err_len_q;
        code_d    = code_q;
        cnt_d     = cnt_q;

        if (beat_fire) begin
            if (full) begin
                err_len_d = 1'b1;
            end else begin
                r_d = r_q + 1'b1;
                if (!in_rng) begin
                    err_rng_d = 1'b1;
                end else begin
                    if (hit) begin
                        err_att_d = 1'b1;
                    end
                    mh_d = mh_q | col_oh;
                    ms_d = ms_q | s_oh;
                    md_d = md_q | d_oh;
                end
            end
            if (in_last) begin
                if (r_q != LN'(N - 1)) begin
                    err_len_d = 1'b1;
                end
                // Length dominates range, range dominates attack.
                if (err_len_d)      code_d = 2'b11;
                else if (err_rng_d) code_d = 2'b10;
                else if (err_att_d) code_d = 2'b01;
                else                code_d = 2'b00;
                state_d = REPORT;
            end
        end

        if (res_fire) begin
            state_d   = COLLECT;
            r_d       = '0;
            mh_d      = '0;
            ms_d      = '0;
            md_d      = '0;
            err_att_d = 1'b0;
            err_rng_d = 1'b0;
            err_len_d = 1'b0;
            if (code_q == 2'b00) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            r_q       <= '0;
            mh_q      <= '0;
            ms_q      <= '0;
            md_q      <= '0;
            err_att_q <= 1'b0;
            err_rng_q <= 1'b0;
            err_len_q <= 1'b0;
            code_q    <= 2'b00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            mh_q      <= mh_d;
            ms_q      <= ms_d;
            md_q      <= md_d;
            err_att_q <= err_att_d;
            err_rng_q <= err_rng_d;
            err_len_q <= err_len_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_queen_check.sv
// Bench for queen_check at N=4: directed boards plus random boards judged by a pairwise
// queen-attack model; one line printed per board verdict.
module tb_queen_check;

    localparam int NQ = 4;
    localparam int LQ = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LQ-1:0] in_col = '0;
    logic          in_last = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [1:0]    res_code;
    logic [31:0]   good_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_good = 0;
    int blen = 0;
    int bcols[16];

    queen_check #(.N(NQ), .LN(LQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_col    (in_col),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_code  (res_code),
        .good_cnt  (good_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Verdict from the board rules: wrong beat count, then any column off the board,
    // then any two on-board queens among the first N rows sharing a column or diagonal.
    function automatic logic [1:0] ref_verdict();
        bit len_e, rng_e, att_e;
        int m, dc;
        len_e = (blen != NQ);
        rng_e = 1'b0;
        att_e = 1'b0;
        m = (blen < NQ) ? blen : NQ;
        for (int i = 0; i < m; i++)
            if (bcols[i] >= NQ) rng_e = 1'b1;
        for (int j = 0; j < m; j++)
            for (int i = 0; i < j; i++)
                if (bcols[i] < NQ && bcols[j] < NQ) begin
                    dc = bcols[i] - bcols[j];
                    if (dc < 0) dc = -dc;
                    if (dc == 0 || dc == (j - i)) att_e = 1'b1;
                end
        if (len_e)      return 2'b11;
        else if (rng_e) return 2'b10;
        else if (att_e) return 2'b01;
        else            return 2'b00;
    endfunction

    task automatic set_board(input int n, input int c0, input int c1, input int c2,
                             input int c3, input int c4, input int c5);
        blen = n;
        bcols[0] = c0; bcols[1] = c1; bcols[2] = c2;
        bcols[3] = c3; bcols[4] = c4; bcols[5] = c5;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the final beat's edge.
    task automatic send_board(input bit with_last, input bit gaps);
        for (int i = 0; i < blen; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            if (!gaps) chk("in_ready_beat", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_col   = LQ'(bcols[i]);
            in_last  = with_last && (i == blen - 1);
            wait_ready();
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_verdict(input int hold, input bit poke);
        logic [1:0] e;
        e = ref_verdict();
        chk("res_valid_lat", {31'd0, res_valid}, 32'd1);
        chk("in_ready_rep", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < hold; k++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_col   = LQ'($urandom_range(0, 7));
                in_last  = 1'b1;
            end
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_code", {30'd0, res_code}, {30'd0, e});
            chk("hold_cnt", good_cnt, exp_good);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("res_code", {30'd0, res_code}, {30'd0, e});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        if (e == 2'b00) exp_good++;
        chk("good_cnt", good_cnt, exp_good);
        chk("in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("res_valid_clr", {31'd0, res_valid}, 32'd0);
        $display("board len=%0d cols=%0d,%0d,%0d,%0d,%0d,%0d code=%0d good=%0d",
                 blen, bcols[0], bcols[1], bcols[2], bcols[3], bcols[4], bcols[5], e, good_cnt);
    endtask

    initial begin
        int sel;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_code", {30'd0, res_code}, 32'd0);
        chk("rst_good_cnt", good_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        set_board(4, 1, 3, 0, 2, 0, 0); send_board(1, 0); get_verdict(0, 0);
        set_board(4, 0, 1, 3, 2, 0, 0); send_board(1, 0); get_verdict(0, 0);
        set_board(4, 1, 3, 4, 2, 0, 0); send_board(1, 0); get_verdict(0, 0);
        set_board(4, 2, 0, 3, 1, 0, 0); send_board(1, 0); get_verdict(0, 0);
        set_board(3, 1, 3, 0, 0, 0, 0); send_board(1, 0); get_verdict(0, 0);
        set_board(6, 1, 3, 0, 2, 1, 3); send_board(1, 0); get_verdict(0, 0);

        // Backpressure with a held (and ignored) input beat during REPORT.
        set_board(4, 2, 0, 3, 1, 0, 0); send_board(1, 0); get_verdict(5, 1);
        set_board(4, 1, 3, 0, 2, 0, 0); send_board(1, 0); get_verdict(0, 0);

        // Reset mid-board.
        set_board(2, 1, 3, 0, 0, 0, 0); send_board(0, 0);
        rst_n = 1'b0;
        #1;
        exp_good = 0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_good_cnt", good_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_board(4, 1, 3, 0, 2, 0, 0); send_board(1, 0); get_verdict(0, 0);

        // Reset while a verdict is pending.
        set_board(4, 2, 0, 3, 1, 0, 0); send_board(1, 0);
        chk("reprst_pre_valid", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_good = 0;
        chk("reprst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reprst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reprst_good_cnt", good_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int b = 0; b < 80; b++) begin
            sel = $urandom_range(0, 11);
            if (sel < 3) begin
                if ($urandom_range(0, 1) == 1) set_board(4, 1, 3, 0, 2, 0, 0);
                else                           set_board(4, 2, 0, 3, 1, 0, 0);
            end else begin
                case (sel)
                    3:       blen = 1;
                    4:       blen = 3;
                    5:       blen = 5;
                    6:       blen = 6;
                    default: blen = 4;
                endcase
                for (int i = 0; i < blen; i++)
                    bcols[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7)
                                                            : $urandom_range(0, 3);
                for (int i = blen; i < 6; i++) bcols[i] = 0;
            end
            send_board(1, 1);
            get_verdict($urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
